button_command_front: RTL and testbench

Upstream front end for the stopwatch control logic. Takes the four raw, asynchronous push-buttons, synchronises and debounces each one, and turns each clean press into a single-cycle, one-hot command pulse. The stopwatch command decoder then acts on clean events instead of on bouncing, multi-hot button levels. Also exports the debounced levels and a conflict flag for the status LEDs.

---
 rtl/button_command_front_pkg.sv | 15 +
 rtl/button_command_front_if.sv | 26 ++
 rtl/button_command_front_debounce_bit.sv | 42 ++++
 rtl/button_command_front.sv | 66 ++++++
 tb/tb_button_command_front.sv | 208 ++++++++++++++++++++
 5 files changed

// File: rtl/button_command_front_pkg.sv
// Shared constants for the stopwatch button front end and command decoder.
// Button indices here are also used by the downstream decoder.
package button_command_front_pkg;

    localparam int BTN_RESET = 3;
    localparam int BTN_STOP  = 2;
    localparam int BTN_UP    = 1;
    localparam int BTN_DOWN  = 0;

    localparam int NUM_BTNS                = 4;
    localparam int DEFAULT_SYNC_LEVEL      = 2;
    localparam int DEFAULT_DEBOUNCE_CYCLES = 65536;
    localparam int DEFAULT_CNT_BITS        = 17;

endpackage

// File: rtl/button_command_front_if.sv
// Button bundle: raw levels in, debounced levels and one-hot commands out.
// The front end takes the slave side; the board or bench takes the master side.
interface button_command_front_if #(
    parameter int BTNS = 4
);

    logic [BTNS-1:0] btn;
    logic [BTNS-1:0] btn_level;
    logic [BTNS-1:0] cmd_pulse;
    logic            conflict;

    modport master (
        output btn,
        input  btn_level,
        input  cmd_pulse,
        input  conflict
    );

    modport slave (
        input  btn,
        output btn_level,
        output cmd_pulse,
        output conflict
    );

endinterface

// File: rtl/button_command_front_debounce_bit.sv
// One button: synchroniser chain, debounce counter and accepted level.
// A level change is taken only after DEBOUNCE_CYCLES consecutive samples.
module debounce_bit
    import button_command_front_pkg::*;
#(
    parameter int SYNC_LEVEL      = DEFAULT_SYNC_LEVEL,
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter int CNT_BITS        = DEFAULT_CNT_BITS
) (
    input  logic clk,
    input  logic reset_n,
    input  logic btn,
    output logic stable
);

    localparam logic [CNT_BITS-1:0] CNT_LAST = CNT_BITS'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_LEVEL-1:0] sync_q;
    logic [CNT_BITS-1:0]   cnt;
    logic                  s;

    assign s = sync_q[SYNC_LEVEL-1];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q <= '0;
            cnt    <= '0;
            stable <= 1'b0;
        end else begin
            sync_q <= (sync_q << 1) | SYNC_LEVEL'(btn);
            if (s == stable) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                stable <= s;
                cnt    <= '0;
            end else begin
                cnt <= cnt + CNT_BITS'(1);
            end
        end
    end

endmodule

// File: rtl/button_command_front.sv
// Debounced buttons to one-hot command pulses with fixed priority.
// Highest index wins; coincident presses raise a one-cycle conflict flag.
module button_command_front
    import button_command_front_pkg::*;
#(
    parameter int BTNS            = NUM_BTNS,
    parameter int SYNC_LEVEL      = DEFAULT_SYNC_LEVEL,
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter int CNT_BITS        = DEFAULT_CNT_BITS
) (
    input logic                   clk,
    input logic                   reset_n,
    button_command_front_if.slave bus
);

    logic [BTNS-1:0] stable;
    logic [BTNS-1:0] prev_q;
    logic [BTNS-1:0] press;
    logic [BTNS-1:0] winner;
    logic [BTNS-1:0] cmd_q;
    logic            multi;
    logic            conflict_q;

    for (genvar i = 0; i < BTNS; i++) begin : g_btn
        debounce_bit #(
            .SYNC_LEVEL      (SYNC_LEVEL),
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .CNT_BITS        (CNT_BITS)
        ) u_debounce (
            .clk     (clk),
            .reset_n (reset_n),
            .btn     (bus.btn[i]),
            .stable  (stable[i])
        );
    end

    assign press = stable & ~prev_q;
    assign multi = (press & (press - BTNS'(1))) != '0;

    // Later iterations overwrite earlier ones, so the highest index wins.
    always_comb begin
        winner = '0;
        for (int i = 0; i < BTNS; i++) begin
            if (press[i]) begin
                winner = BTNS'(1) << i;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            prev_q     <= '0;
            cmd_q      <= '0;
            conflict_q <= 1'b0;
        end else begin
            prev_q     <= stable;
            cmd_q      <= winner;
            conflict_q <= multi;
        end
    end

    assign bus.btn_level = stable;
    assign bus.cmd_pulse = cmd_q;
    assign bus.conflict  = conflict_q;

endmodule

// File: tb/tb_button_command_front.sv
// Directed bench for button_command_front with SYNC_LEVEL=2, DEBOUNCE_CYCLES=4.
// Edge k means the k-th rising edge after the stimulus change; sampling is on the falling edge.
module tb_button_command_front;

    localparam int BTNS = 4;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    button_command_front_if #(.BTNS(BTNS)) bus ();

    button_command_front #(
        .BTNS            (BTNS),
        .SYNC_LEVEL      (2),
        .DEBOUNCE_CYCLES (4),
        .CNT_BITS        (3)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic test_reset();
        bus.btn = 4'b1111;
        reset_n = 1'b0;
        idle(3);
        checks++;
        if (bus.btn_level !== 4'b0 || bus.cmd_pulse !== 4'b0 || bus.conflict !== 1'b0) begin
            errors++;
            $display("FAIL reset: level=%b pulse=%b conflict=%b, required 0000/0000/0",
                     bus.btn_level, bus.cmd_pulse, bus.conflict);
        end
        bus.btn = 4'b0;
        reset_n = 1'b1;
        idle(4);
    endtask

    task automatic test_clean_press();
        logic [3:0] el, ep;
        bus.btn = 4'b0010;
        for (int k = 0; k < 20; k++) begin
            step();
            el = (k >= 5) ? 4'b0010 : 4'b0000;
            ep = (k == 6) ? 4'b0010 : 4'b0000;
            checks++;
            if (bus.btn_level !== el || bus.cmd_pulse !== ep || bus.conflict !== 1'b0) begin
                errors++;
                $display("FAIL clean_press edge %0d: level=%b pulse=%b conflict=%b, required %b/%b/0",
                         k, bus.btn_level, bus.cmd_pulse, bus.conflict, el, ep);
            end
        end
        bus.btn = 4'b0;
        for (int k = 0; k < 10; k++) begin
            step();
            el = (k >= 5) ? 4'b0000 : 4'b0010;
            checks++;
            if (bus.btn_level !== el || bus.cmd_pulse !== 4'b0) begin
                errors++;
                $display("FAIL release edge %0d: level=%b pulse=%b, required %b/0000",
                         k, bus.btn_level, bus.cmd_pulse, el);
            end
        end
    endtask

    task automatic test_bounce();
        logic [4:0] seq;
        logic [3:0] el, ep;
        seq = 5'b01101;
        for (int j = 0; j < 20; j++) begin
            bus.btn = {1'b0, (j < 5) ? seq[j] : 1'b1, 2'b00};
            step();
            el = (j >= 10) ? 4'b0100 : 4'b0000;
            ep = (j == 11) ? 4'b0100 : 4'b0000;
            checks++;
            if (bus.btn_level !== el || bus.cmd_pulse !== ep) begin
                errors++;
                $display("FAIL bounce edge %0d: level=%b pulse=%b, required %b/%b",
                         j, bus.btn_level, bus.cmd_pulse, el, ep);
            end
        end
        bus.btn = 4'b0;
        idle(10);
    endtask

    task automatic test_glitch();
        for (int j = 0; j < 14; j++) begin
            bus.btn = (j < 3) ? 4'b0001 : 4'b0000;
            step();
            checks++;
            if (bus.btn_level !== 4'b0 || bus.cmd_pulse !== 4'b0) begin
                errors++;
                $display("FAIL glitch edge %0d: level=%b pulse=%b, required 0000/0000",
                         j, bus.btn_level, bus.cmd_pulse);
            end
        end
    endtask

    task automatic test_conflict();
        logic [3:0] el, ep;
        logic       ec;
        bus.btn = 4'b1010;
        for (int k = 0; k < 12; k++) begin
            step();
            el = (k >= 5) ? 4'b1010 : 4'b0000;
            ep = (k == 6) ? 4'b1000 : 4'b0000;
            ec = (k == 6);
            checks++;
            if (bus.btn_level !== el || bus.cmd_pulse !== ep || bus.conflict !== ec) begin
                errors++;
                $display("FAIL conflict edge %0d: level=%b pulse=%b conflict=%b, required %b/%b/%b",
                         k, bus.btn_level, bus.cmd_pulse, bus.conflict, el, ep, ec);
            end
        end
        bus.btn = 4'b0;
        idle(10);
    endtask

    task automatic test_reset_mid();
        logic [3:0] el, ep;
        bus.btn = 4'b0100;
        idle(4);
        reset_n = 1'b0;
        for (int k = 0; k < 4; k++) begin
            step();
            checks++;
            if (bus.btn_level !== 4'b0 || bus.cmd_pulse !== 4'b0 || bus.conflict !== 1'b0) begin
                errors++;
                $display("FAIL reset_mid hold %0d: level=%b pulse=%b conflict=%b, required 0000/0000/0",
                         k, bus.btn_level, bus.cmd_pulse, bus.conflict);
            end
        end
        reset_n = 1'b1;
        for (int k = 0; k < 12; k++) begin
            step();
            el = (k >= 5) ? 4'b0100 : 4'b0000;
            ep = (k == 6) ? 4'b0100 : 4'b0000;
            checks++;
            if (bus.btn_level !== el || bus.cmd_pulse !== ep || bus.conflict !== 1'b0) begin
                errors++;
                $display("FAIL reset_mid edge %0d: level=%b pulse=%b conflict=%b, required %b/%b/0",
                         k, bus.btn_level, bus.cmd_pulse, bus.conflict, el, ep);
            end
        end
        bus.btn = 4'b0;
        idle(10);
    endtask

    task automatic test_back_to_back();
        logic [3:0] el, ep;
        bus.btn = 4'b0010;
        for (int k = 0; k < 10; k++) begin
            step();
            ep = (k == 6) ? 4'b0010 : 4'b0000;
            checks++;
            if (bus.cmd_pulse !== ep) begin
                errors++;
                $display("FAIL hold_first edge %0d: pulse=%b, required %b", k, bus.cmd_pulse, ep);
            end
        end
        bus.btn = 4'b0011;
        for (int k = 0; k < 12; k++) begin
            step();
            el = (k >= 5) ? 4'b0011 : 4'b0010;
            ep = (k == 6) ? 4'b0001 : 4'b0000;
            checks++;
            if (bus.btn_level !== el || bus.cmd_pulse !== ep || bus.conflict !== 1'b0) begin
                errors++;
                $display("FAIL hold_second edge %0d: level=%b pulse=%b conflict=%b, required %b/%b/0",
                         k, bus.btn_level, bus.cmd_pulse, bus.conflict, el, ep);
            end
        end
        bus.btn = 4'b0;
        idle(10);
        checks++;
        if (bus.btn_level !== 4'b0) begin
            errors++;
            $display("FAIL final_release: level=%b, required 0000", bus.btn_level);
        end
    endtask

    initial begin
        bus.btn = 4'b0;
        @(negedge clk);
        test_reset();
        test_clean_press();
        test_bounce();
        test_glitch();
        test_conflict();
        test_reset_mid();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
